bcd_serial_adder: RTL
=====================

# bcd_serial_adder

Parametrised, digit-serial packed-BCD adder/subtractor. It is the sequential successor of the team's single-digit combinational BCD sum block. One BCD digit is processed per clock, least-significant digit first, so a single digit adder serves any operand width. Upstream logic hands it operands with a start/done handshake. It sits between the BCD operand registers and the display/result path.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per operand. Must be ≥ 1.

Ports:
- clk  in  1  : the single clock. All state changes on its rising edge.
- rst  in  1  : reset. Synchronous and active-high.
- start  in  1  : request. Sampled only in IDLE.
- sub  in  1  : mode select, latched at start. 0 = a + b + cin; 1 = a − b (ten's complement).
- cin  in  1  : carry-in for add mode, latched at start. Ignored when sub = 1.
- a  in  4*DIGITS  : packed BCD operand, digit 0 in bits [3:0]. Latched at start.
- b  in  4*DIGITS  : packed BCD operand, same format as a. Latched at start.
- z  out  4*DIGITS  : packed BCD result. Registered.
- cout  out  1  : final carry. In sub mode, 1 = no borrow (a ≥ b).
- busy  out  1  : high while operands are being processed.
- done  out  1  : one-cycle pulse when z and cout are valid.
- invalid  out  1  : some latched digit of a or b was > 9. Sticky until the next accepted start.

## Operation
- FSM states:
  - IDLE → RUN when start = 1. On this transition: latch a, b, sub, cin; set idx = 0; set carry = sub ? 1 : cin; compute invalid from the latched operands.
  - RUN: process digit idx, then idx += 1. After digit DIGITS−1, go to DONE.
  - DONE: lasts one cycle, then → IDLE.
- Digit step:
  - bd = sub ? (9 − b_d) mod 16 : b_d.
  - s = a_d + bd + carry, 5 bits wide.
  - If s > 9: digit = (s + 6)[3:0] and carry = 1. Otherwise digit = s[3:0] and carry = 0.
- Digits are collected in an internal shift register. z and cout are written only on entry to DONE. They hold their value through the following IDLE and RUN until the next DONE.
- Invalid digits are still processed with the digit-step rule above. The result is defined by that rule but is not meaningful BCD.
- Sub result: z = (a − b) mod 10^DIGITS. When cout = 0 the true result is negative and z is its ten's complement.
- start is ignored in RUN and DONE; nothing is queued.

## Timing
- Reset values: state = IDLE, z = 0, cout = 0, busy = 0, done = 0, invalid = 0, idx = 0.
- Latency: start sampled at edge k. RUN covers edges k+1 … k+DIGITS. done is high for the cycle after edge k+DIGITS, when z and cout are already valid.
- busy is high for the DIGITS cycles after edge k. It is low in DONE and IDLE.
- Throughput: one operation every DIGITS + 2 cycles. A start asserted during the DONE cycle is not accepted; it must be held into IDLE.
- invalid updates at edge k. It is stable for the whole operation and after it.
- Reset mid-operation: abort immediately, all outputs to their reset values. No done pulse is produced.
- DIGITS = 1: RUN lasts exactly one cycle.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - constants BCD_MAX = 9 and BCD_CORR = 6;
  - the digit-width constant 4.
- Sub-module bcd_digit_adder: purely combinational. Inputs a_d, bd, carry_in; outputs digit, carry_out. It is instantiated once and time-shared across all digits.
- Top level contains the FSM, the idx counter (width $clog2(DIGITS+1)), the operand shift registers and the result register.

## Test plan
- DIGITS = 4, add 0x1234 + 0x5678, cin = 0 → z = 0x6912, cout = 0. done pulses exactly 5 cycles after the start edge; busy high for 4 cycles.
- Add 0x9999 + 0x0001, cin = 0 → z = 0x0000, cout = 1. Add 0x0999 + 0x0000, cin = 1 → z = 0x1000, cout = 0.
- Sub 0x0500 − 0x0123 → z = 0x0377, cout = 1. Sub 0x0123 − 0x0500 → z = 0x9623, cout = 0. Sub 0x4321 − 0x4321 → z = 0x0000, cout = 1.
- a = 0x00A0, b = 0x0000, add → invalid = 1 from the edge after start, through done, until the next start. A following valid start clears it.
- Pulse start again during RUN and during DONE → ignored, with no second done. Assert rst during RUN → z = 0, cout = 0, busy = 0, done = 0 on the next edge. A subsequent start completes correctly.
- DIGITS = 1: 0x7 + 0x5 → z = 0x2, cout = 1, done 2 cycles after start. DIGITS = 8: random valid operands checked against a reference model, 1000 iterations.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
// Holds the controller state encoding and the BCD digit constants used by
// both the time-shared digit adder and the top-level sequencer.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder, purely combinational.
// Ports:
//   a_d       in  4 : operand digit
//   bd        in  4 : second operand digit (already nine's-complemented in sub mode)
//   carry_in  in  1 : incoming decimal carry
//   digit     out 4 : corrected BCD sum digit
//   carry_out out 1 : decimal carry to the next digit
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] bd,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a_d} + {1'b0, bd} + {4'b0, carry_in};
        if (s > {1'b0, BCD_MAX}) begin
            // 4-bit wrap of s + 6 is exactly (s + 6)[3:0]
            digit     = s[3:0] + BCD_CORR;
            carry_out = 1'b1;
        end else begin
            digit     = s[3:0];
            carry_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Ports:
//   clk      in  1          : clock, rising edge
//   rst      in  1          : synchronous active-high reset
//   start    in  1          : operation request, sampled only in IDLE
//   sub      in  1          : 0 = a + b + cin, 1 = a - b (ten's complement)
//   cin      in  1          : carry-in for add mode
//   a, b     in  4*DIGITS   : packed BCD operands, digit 0 in [3:0]
//   z        out 4*DIGITS   : registered packed BCD result
//   cout     out 1          : final carry (sub mode: 1 = no borrow)
//   busy     out 1          : digits are being processed
//   done     out 1          : one-cycle pulse, z/cout valid
//   invalid  out 1          : a latched digit was > 9, sticky until next start
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one digit processed per cycle, idx counts 0 .. DIGITS-1
// DONE  | single-cycle done pulse, z/cout just written
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic                    cin,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    output logic [4*DIGITS-1:0]     z,
    output logic                    cout,
    output logic                    busy,
    output logic                    done,
    output logic                    invalid
);

    localparam int                W        = DIGIT_W * DIGITS;
    localparam int                IDX_W    = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     res_sh;
    logic [W-1:0]     res_next;
    logic             sub_q;
    logic             carry_q;
    logic [3:0]       bd;
    logic [3:0]       digit;
    logic             carry_out;
    logic             last_digit;
    logic             any_bad;

    // Nine's complement of the subtrahend digit; with carry preset to 1 this
    // forms the ten's complement. Out-of-range digits wrap mod 16.
    assign bd         = sub_q ? (BCD_MAX - b_sh[3:0]) : b_sh[3:0];
    assign last_digit = (idx_q == IDX_LAST);

    // New digit enters at the top so digit 0 ends up in [3:0] after DIGITS shifts
    assign res_next = W'({digit, res_sh} >> DIGIT_W);

    bcd_digit_adder u_digit (
        .a_d       (a_sh[3:0]),
        .bd        (bd),
        .carry_in  (carry_q),
        .digit     (digit),
        .carry_out (carry_out)
    );

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[DIGIT_W*i +: DIGIT_W] > BCD_MAX) ||
                (b[DIGIT_W*i +: DIGIT_W] > BCD_MAX)) begin
                any_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            z       <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        sub_q   <= sub;
                        carry_q <= sub | cin;
                        idx_q   <= '0;
                        invalid <= any_bad;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT_W;
                    b_sh    <= b_sh >> DIGIT_W;
                    res_sh  <= res_next;
                    carry_q <= carry_out;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_digit) begin
                        z    <= res_next;
                        cout <= carry_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
